atanh_lut_search: RTL

//  Inverse of the tanh activation: given y in Q(N-Q).Q, returns x = atanh(y) in the same format.
//  - Bit-serial binary search over the monotone tanh ROM, then a restoring divide for linear interpolation.
//  - Sits next to the activation path; the training/denoise back-end uses it to map activations back to pre-activations.
//  - Multi-cycle, one operation in flight, valid/ready on both sides.

---
 rtl/atanh_lut_search_if.sv | 32 +++
 rtl/atanh_lut_search.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atanh_lut_search_if.sv
// ---------------------------------------------------------------------------
// atanh_lut_search_if
// Purpose : valid/ready request and response channels of atanh_lut_search.
// Signals :
//   in_valid  requester -> core   y_in is valid
//   in_ready  core -> requester   core is idle and accepts y_in
//   y_in      requester -> core   tanh-domain operand, Q(N-Q).Q
//   out_valid core -> requester   x_out is valid, held until accepted
//   out_ready requester -> core   requester accepts x_out
//   x_out     core -> requester   atanh(y_in), Q(N-Q).Q
// Modports: master (requester side), slave (core side).
// ---------------------------------------------------------------------------
interface atanh_lut_search_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] y_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] x_out;

  modport master (
    output in_valid, y_in, out_ready,
    input  in_ready, out_valid, x_out
  );

  modport slave (
    input  in_valid, y_in, out_ready,
    output in_ready, out_valid, x_out
  );
endinterface

// File: rtl/atanh_lut_search.sv
// ---------------------------------------------------------------------------
// atanh_lut_search
// Purpose : x = atanh(y) for y in Q(N-Q).Q, result in the same format.
//   A binary search over a monotone tanh table finds the segment k with
//   T[k] <= |y| < T[k+1]; a restoring divide then interpolates linearly
//   inside the segment. One operation in flight, valid/ready on both sides.
//   Out-of-range inputs (|y| >= 1.0, or |y| beyond the last table entry)
//   saturate to 4.0 - 1 LSB with the sign of y.
// Ports   :
//   clk  in  single clock, rising edge
//   rst  in  synchronous reset, active-high
//   bus  atanh_lut_search_if.slave : in_valid/in_ready/y_in request,
//        out_valid/out_ready/x_out response
// Table   : entry k holds floor(tanh(k * 2^-(AW-2)) * 2^Q). The contents are
//   generated at elaboration from that definition, so no memory image file
//   is needed; the table is read through a registered (1-cycle) port.
// Config  : define ATANH_ROUND_EN to compute one extra quotient bit and round
//   the interpolation half-up (latency 2*AW+IB+6 instead of 2*AW+IB+5).
// ---------------------------------------------------------------------------
module atanh_lut_search #(
  parameter int N  = 32,
  parameter int Q  = 16,
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int IB = 8
) (
  input  logic              clk,
  input  logic              rst,
  atanh_lut_search_if.slave bus
);

  // Magnitudes are handled unsigned on N+1 bits so |0x80..0| fits.
  localparam int LP_W    = N + 1;
  localparam int LP_SK   = Q - AW + 2;      // weight of k in the result
  localparam int LP_SQ   = LP_SK - IB;      // weight of the quotient LSB
`ifdef ATANH_ROUND_EN
  localparam int LP_QB   = IB + 1;
`else
  localparam int LP_QB   = IB;
`endif
  localparam int LP_BW   = (AW > 1) ? $clog2(AW) : 1;
  localparam int LP_CW   = $clog2(LP_QB + 1);
  localparam int LP_F    = 48;              // fraction bits of table generator
  localparam int LP_XS   = AW - 3;          // 2*step = 2^-(AW-3)
  localparam logic [LP_W-1:0] LP_ONE     = LP_W'(1) << Q;
  localparam logic [LP_W-1:0] LP_SAT_MAG = (LP_W'(1) << (Q + 2)) - LP_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ABS, S_SRCH_A, S_SRCH_C, S_FET0, S_FET1, S_FET2, S_DIV, S_OUT
  } state_t;

  // floor(tanh(k*2^-(AW-2)) * 2^Q) = floor(2^Q*(e-1)/(e+1)), e = exp(2x).
  // exp(2x) is built by binary powering of exp(2^-(AW-3)), itself a short
  // Taylor series; 48 fraction bits keep the error far below one output LSB.
  function automatic logic [DW-1:0] f_tanh_q(input int unsigned k);
    logic [127:0] one, term, c, e, num, den;
    one  = 128'd1 << LP_F;
    term = one;
    c    = one;
    for (int n = 1; n < 12; n++) begin
      term = (term >> LP_XS) / 128'(n);
      c    = c + term;
    end
    e = one;
    for (int b = 0; b < AW; b++) begin
      if (k[b]) e = (e * c) >> LP_F;
      c = (c * c) >> LP_F;
    end
    num = (e - one) << Q;
    den = e + one;
    return DW'(num / den);
  endfunction

  function automatic logic [LP_W-1:0] f_abs(input logic [N-1:0] y);
    logic [LP_W-1:0] ext;
    ext = {y[N-1], y};
    return y[N-1] ? (~ext + LP_W'(1)) : ext;
  endfunction

  // Segment index plus interpolation fraction, or the saturation value.
  function automatic logic [LP_W-1:0] f_mag(input logic [AW-1:0] k,
                                            input logic [LP_QB-1:0] q,
                                            input logic sat);
    logic [LP_W-1:0] qr;
`ifdef ATANH_ROUND_EN
    // A carry out of the rounded fraction lands on the k weight naturally.
    qr = (LP_W'(q) + LP_W'(1)) >> 1;
`else
    qr = LP_W'(q);
`endif
    if (sat) return LP_SAT_MAG;
    return (LP_W'(k) << LP_SK) + (qr << LP_SQ);
  endfunction

  function automatic logic [N-1:0] f_sign(input logic [LP_W-1:0] mag,
                                          input logic sgn);
    logic [LP_W-1:0] v;
    v = sgn ? (~mag + LP_W'(1)) : mag;
    return v[N-1:0];
  endfunction

  logic [DW-1:0] w_rom [2**AW];

  for (genvar g = 0; g < 2**AW; g++) begin : g_rom
    localparam logic [DW-1:0] LP_T = f_tanh_q(g);
    assign w_rom[g] = LP_T;
  end

  state_t           r_state, w_next;
  logic [N-1:0]     r_y;
  logic             r_sgn;
  logic [LP_W-1:0]  r_a;
  logic             r_sat;
  logic [AW-1:0]    r_k;
  logic [LP_BW-1:0] r_bit;
  logic [LP_W-1:0]  r_lo;
  logic [LP_W-1:0]  r_r;
  logic [LP_W-1:0]  r_d;
  logic [LP_QB-1:0] r_q;
  logic [LP_CW-1:0] r_cnt;
  logic [DW-1:0]    r_rom_q;
  logic [N-1:0]     r_x_out;
  logic             r_out_valid;

  logic [AW-1:0]    w_cand;
  logic [AW-1:0]    w_rom_addr;
  logic             w_take;
  logic [LP_W:0]    w_r2;
  logic             w_qbit;
  logic [LP_W:0]    w_rsub;
  logic [LP_W-1:0]  w_hi;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.x_out     = r_x_out;

  // Candidate k with the current search bit set; the top index is excluded
  // because every segment needs an upper neighbour.
  assign w_cand = r_k | (AW'(1) << r_bit);
  assign w_take = (w_cand != {AW{1'b1}}) && (LP_W'(r_rom_q) <= r_a);

  assign w_hi   = LP_W'(r_rom_q);
  assign w_r2   = {r_r, 1'b0};
  assign w_qbit = (w_r2 >= {1'b0, r_d});
  assign w_rsub = w_qbit ? (w_r2 - {1'b0, r_d}) : w_r2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rom_addr = r_k;
    case (r_state)
      S_IDLE:   if (bus.in_valid) w_next = S_ABS;
      S_ABS:    w_next = S_SRCH_A;
      S_SRCH_A: begin
        w_rom_addr = w_cand;
        w_next     = S_SRCH_C;
      end
      S_SRCH_C: w_next = (r_bit == '0) ? S_FET0 : S_SRCH_A;
      S_FET0:   w_next = S_FET1;
      S_FET1: begin
        w_rom_addr = r_k + AW'(1);
        w_next     = S_FET2;
      end
      S_FET2:   w_next = S_DIV;
      S_DIV:    if (r_cnt == LP_CW'(LP_QB - 1)) w_next = S_OUT;
      S_OUT:    if (r_out_valid && bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_rom_q <= '0;
    else     r_rom_q <= w_rom[w_rom_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y         <= '0;
      r_sgn       <= 1'b0;
      r_a         <= '0;
      r_sat       <= 1'b0;
      r_k         <= '0;
      r_bit       <= '0;
      r_lo        <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_x_out     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        // accept: operand captured only on the handshake edge
        S_IDLE: if (bus.in_valid) r_y <= bus.y_in;
        // sign/magnitude split and range check
        S_ABS: begin
          r_sgn <= r_y[N-1];
          r_a   <= f_abs(r_y);
          r_sat <= (r_y == {1'b1, {(N-1){1'b0}}}) || (f_abs(r_y) >= LP_ONE);
          r_k   <= '0;
          r_bit <= LP_BW'(AW - 1);
        end
        // search compare: table word for w_cand is on r_rom_q now
        S_SRCH_C: begin
          if (w_take) r_k <= w_cand;
          if (r_bit != '0) r_bit <= r_bit - LP_BW'(1);
        end
        // segment endpoints
        S_FET1: r_lo <= LP_W'(r_rom_q);
        S_FET2: begin
          if (r_a >= w_hi) r_sat <= 1'b1;
          r_r   <= r_a - r_lo;
          r_d   <= w_hi - r_lo;
          r_q   <= '0;
          r_cnt <= '0;
        end
        // restoring divide, one quotient bit per cycle
        S_DIV: begin
          r_r   <= w_rsub[LP_W-1:0];
          r_q   <= {r_q[LP_QB-2:0], w_qbit};
          r_cnt <= r_cnt + LP_CW'(1);
        end
        // result formed in the first OUT cycle, then held until accepted
        S_OUT: begin
          if (!r_out_valid) begin
            r_x_out     <= f_sign(f_mag(r_k, r_q, r_sat), r_sgn);
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
